// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared definitions for the SPI configuration sequencer.
// Holds the frame width shared with the SPI engine, the FSM state encoding
// and the readback check (the chip echoes LSB-first, the engine shifts MSB-first).
package spi_seq_pkg;

    localparam int SPI_NDATA = 48;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
    localparam logic [2:0] ST_CHECK     = 3'd4;
    localparam logic [2:0] ST_GAP       = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        START     = ST_START,
        WAIT_LOW  = ST_WAIT_LOW,
        WAIT_HIGH = ST_WAIT_HIGH,
        CHECK     = ST_CHECK,
        GAP       = ST_GAP
    } state_t;

    // True when rb[ndata-1-i] == wr[i] for every i < ndata.
    function automatic logic bitrev_match(input logic [63:0] wr,
                                          input logic [63:0] rb,
                                          input int          ndata);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i < ndata) begin
                ok = ok & (rb[6'(ndata - 1 - i)] == wr[6'(i)]);
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/spi_seq_refresh_timer.sv
// spi_seq_refresh_timer: free-running refresh interval counter with a sticky
// pending flag. Used by spi_cfg_sequencer only when SPI_SEQ_REFRESH_EN is defined.
import spi_seq_pkg::*;

module spi_seq_refresh_timer #(
    parameter int REFRESH_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic refresh_en,
    input  logic clear,
    output logic expire
);

    localparam logic [31:0] CNT_LAST = 32'(REFRESH_CYC - 1);

    logic [31:0] cnt_r;
    logic        pend_r;

    // Count enabled cycles, wrapping at the end of each refresh interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 32'd0;
        end else if (!refresh_en) begin
            cnt_r <= 32'd0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= 32'd0;
        end else begin
            cnt_r <= cnt_r + 32'd1;
        end
    end

    // Latch an expiry until the sequencer consumes it; a fresh expiry wins over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= 1'b0;
        end else if (refresh_en && (cnt_r == CNT_LAST)) begin
            pend_r <= 1'b1;
        end else if (clear) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= pend_r;
        end
    end

    assign expire = pend_r;

endmodule

// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: front end for the 48-bit SPI configuration engine.
// Captures host words, starts the engine, follows the swr profile to detect
// completion, verifies the bit-reversed echo and retries on mismatch.
// Macro SPI_SEQ_REFRESH_EN adds the periodic rewrite of the verified shadow word.
import spi_seq_pkg::*;

module spi_cfg_sequencer #(
    parameter int NDATA       = SPI_NDATA,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 1024,
    parameter int REFRESH_CYC = 1000000,
    parameter int GAP_CYC     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_req,
    input  logic [63:0] host_data,
    output logic        host_ack,
    input  logic        refresh_en,
    output logic        spi_en,
    output logic [63:0] spi_masterdata,
    input  logic        spi_swr,
    input  logic [63:0] spi_readback,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] err_cnt,
    output logic [63:0] last_readback,
    output logic [63:0] shadow
);

    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYC - 1);

    state_t             state_r;
    logic [NDATA-1:0]   working_r;
    logic [NDATA-1:0]   shadow_r;
    logic [7:0]         retry_r;
    logic [7:0]         gap_r;
    logic [31:0]        tmo_r;
    logic               retry_pend_r;
    logic               host_ack_r;
    logic               spi_en_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic [15:0]        err_cnt_r;
    logic [63:0]        last_readback_r;
    logic               pass_s;
    logic               refresh_go_s;
    logic               unused_s;

`ifdef SPI_SEQ_REFRESH_EN
    logic shadow_valid_r;
    logic refresh_pend_s;
    logic refresh_clear_s;

    spi_seq_refresh_timer #(
        .REFRESH_CYC (REFRESH_CYC)
    ) u_refresh_timer (
        .clk        (clk),
        .rst        (rst),
        .refresh_en (refresh_en),
        .clear      (refresh_clear_s),
        .expire     (refresh_pend_s)
    );

    // Consume a pending refresh in IDLE when the host is quiet; drop it if no word was ever verified.
    always_comb begin
        refresh_clear_s = 1'b0;
        refresh_go_s    = 1'b0;
        if ((state_r == IDLE) && !host_req && refresh_en && refresh_pend_s) begin
            refresh_clear_s = 1'b1;
            refresh_go_s    = shadow_valid_r;
        end else begin
            refresh_clear_s = 1'b0;
            refresh_go_s    = 1'b0;
        end
    end

    assign unused_s = ^host_data[63:NDATA];
`else
    assign refresh_go_s = 1'b0;
    assign unused_s     = ^{host_data[63:NDATA], refresh_en, (REFRESH_CYC > 0)};
`endif

    assign spi_masterdata = {{(64-NDATA){1'b0}}, working_r};
    assign shadow         = {{(64-NDATA){1'b0}}, shadow_r};
    assign pass_s         = bitrev_match(spi_masterdata, spi_readback, NDATA);

    assign host_ack      = host_ack_r;
    assign spi_en        = spi_en_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign err_cnt       = err_cnt_r;
    assign last_readback = last_readback_r;

    // Transaction FSM with all host- and engine-facing outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            working_r       <= '0;
            shadow_r        <= '0;
            retry_r         <= 8'd0;
            gap_r           <= 8'd0;
            tmo_r           <= 32'd0;
            retry_pend_r    <= 1'b0;
            host_ack_r      <= 1'b0;
            spi_en_r        <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            err_r           <= 1'b0;
            err_cnt_r       <= 16'd0;
            last_readback_r <= 64'd0;
`ifdef SPI_SEQ_REFRESH_EN
            shadow_valid_r  <= 1'b0;
`endif
        end else begin
            host_ack_r <= 1'b0;
            spi_en_r   <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (host_req) begin
                        working_r  <= host_data[NDATA-1:0];
                        host_ack_r <= 1'b1;
                        err_r      <= 1'b0;
                        state_r    <= START;
                    end else if (refresh_go_s) begin
                        working_r <= shadow_r;
                        state_r   <= START;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    spi_en_r <= 1'b1;
                    busy_r   <= 1'b1;
                    tmo_r    <= 32'd0;
                    state_r  <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!spi_swr) begin
                        tmo_r   <= 32'd0;
                        state_r <= WAIT_HIGH;
                    end else if (tmo_r == TMO_LAST) begin
                        err_r        <= 1'b1;
                        retry_pend_r <= 1'b0;
                        gap_r        <= 8'd0;
                        state_r      <= GAP;
                    end else begin
                        tmo_r <= tmo_r + 32'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (spi_swr) begin
                        tmo_r   <= 32'd0;
                        state_r <= CHECK;
                    end else if (tmo_r == TMO_LAST) begin
                        err_r        <= 1'b1;
                        retry_pend_r <= 1'b0;
                        gap_r        <= 8'd0;
                        state_r      <= GAP;
                    end else begin
                        tmo_r <= tmo_r + 32'd1;
                    end
                end
                CHECK: begin
                    last_readback_r <= spi_readback;
                    gap_r           <= 8'd0;
                    state_r         <= GAP;
                    if (pass_s) begin
                        shadow_r     <= working_r;
                        retry_pend_r <= 1'b0;
`ifdef SPI_SEQ_REFRESH_EN
                        shadow_valid_r <= 1'b1;
`endif
                    end else begin
                        if (err_cnt_r != 16'hFFFF) begin
                            err_cnt_r <= err_cnt_r + 16'd1;
                        end else begin
                            err_cnt_r <= err_cnt_r;
                        end
                        if (retry_r < RETRY_MAX) begin
                            retry_r      <= retry_r + 8'd1;
                            retry_pend_r <= 1'b1;
                        end else begin
                            err_r        <= 1'b1;
                            retry_pend_r <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_r == GAP_LAST) begin
                        if (retry_pend_r) begin
                            state_r <= START;
                        end else begin
                            state_r <= IDLE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            retry_r <= 8'd0;
                        end
                    end else begin
                        gap_r <= gap_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Scoreboard bench for spi_cfg_sequencer with a behavioural SPI engine/chip.
`timescale 1ns/1ps
module tb_spi_cfg_sequencer;
    import spi_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_req;
    logic [63:0] host_data;
    logic        host_ack;
    logic        refresh_en;
    logic        spi_en;
    logic [63:0] spi_masterdata;
    logic        spi_swr;
    logic [63:0] spi_readback;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] err_cnt;
    logic [63:0] last_readback;
    logic [63:0] shadow;

    always #5 clk = ~clk;

    spi_cfg_sequencer #(
        .MAX_RETRY   (3),
        .TIMEOUT_CYC (1024),
        .REFRESH_CYC (200),
        .GAP_CYC     (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .host_req       (host_req),
        .host_data      (host_data),
        .host_ack       (host_ack),
        .refresh_en     (refresh_en),
        .spi_en         (spi_en),
        .spi_masterdata (spi_masterdata),
        .spi_swr        (spi_swr),
        .spi_readback   (spi_readback),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .err_cnt        (err_cnt),
        .last_readback  (last_readback),
        .shadow         (shadow)
    );

    int errors = 0;
    int checks = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Chip echo: the chip returns the word LSB-first, the engine shifts MSB-first.
    function automatic logic [63:0] echo(input logic [63:0] w, input bit flip);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < SPI_NDATA; i++) r[SPI_NDATA-1-i] = w[i];
        if (flip) r[0] = ~r[0];
        return r;
    endfunction

    // ---------------- behavioural engine + chip ----------------
    // spi_en seen at edge E0; swr low from E54 to E102; readback valid at E102.
    logic eng_active;
    int   eng_cnt;
    int   eng_txn = 0;
    int   corrupt_until = 0;
    bit   always_corrupt = 1'b0;
    bit   stuck_high = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_active   <= 1'b0;
            eng_cnt      <= 0;
            spi_swr      <= 1'b1;
            spi_readback <= 64'd0;
        end else if (!eng_active) begin
            if (spi_en) begin
                eng_active <= 1'b1;
                eng_cnt    <= 0;
            end
        end else begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == 53 && !stuck_high) spi_swr <= 1'b0;
            if (eng_cnt == 101) begin
                spi_swr      <= 1'b1;
                eng_active   <= 1'b0;
                spi_readback <= echo(spi_masterdata, always_corrupt || (eng_txn < corrupt_until));
                eng_txn      <= eng_txn + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        logic [63:0] word;
        logic        err;
        logic [15:0] err_cnt;
        logic [63:0] shadow;
        logic [63:0] rb;
        int          attempts;
        int          latency;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t mk(input string n, input logic [63:0] w, input logic e,
                                input logic [15:0] c, input logic [63:0] s,
                                input logic [63:0] rb, input int a, input int l);
        exp_t x;
        x.name = n; x.word = w; x.err = e; x.err_cnt = c; x.shadow = s;
        x.rb = rb; x.attempts = a; x.latency = l;
        return x;
    endfunction

    int spi_en_total = 0;

    // Monitor: counts attempts/latency, pops an expectation on every done pulse.
    initial begin
        bit   in_txn;
        int   attempts;
        int   cyc;
        exp_t e;
        in_txn = 1'b0; attempts = 0; cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_txn = 1'b0; attempts = 0; cyc = 0;
            end else begin
                if (in_txn) cyc++;
                if (spi_en) begin
                    spi_en_total++;
                    if (!in_txn) begin in_txn = 1'b1; cyc = -1; end
                    attempts++;
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got done=1, expected no transaction");
                    end else begin
                        e = exp_q.pop_front();
                        check64($sformatf("%s_word", e.name), spi_masterdata, e.word);
                        check64($sformatf("%s_err", e.name), 64'(err), 64'(e.err));
                        check64($sformatf("%s_err_cnt", e.name), 64'(err_cnt), 64'(e.err_cnt));
                        check64($sformatf("%s_shadow", e.name), shadow, e.shadow);
                        check64($sformatf("%s_last_rb", e.name), last_readback, e.rb);
                        check64($sformatf("%s_busy", e.name), 64'(busy), 64'd0);
                        check64($sformatf("%s_attempts", e.name), 64'(attempts), 64'(e.attempts));
                        check64($sformatf("%s_latency", e.name), 64'(cyc), 64'(e.latency));
                    end
                    in_txn = 1'b0; attempts = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [63:0] d, input exp_t e, output int waited);
        exp_q.push_back(e);
        host_req  = 1'b1;
        host_data = d;
        waited = 0;
        do begin @(negedge clk); waited++; end while (!host_ack && waited < 3000);
        check64({e.name, "_ack"}, 64'(host_ack), 64'd1);
        host_req = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
        check64({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check64({name, "_host_ack"}, 64'(host_ack), 64'd0);
        check64({name, "_spi_en"}, 64'(spi_en), 64'd0);
        check64({name, "_masterdata"}, spi_masterdata, 64'd0);
        check64({name, "_busy"}, 64'(busy), 64'd0);
        check64({name, "_done"}, 64'(done), 64'd0);
        check64({name, "_err"}, 64'(err), 64'd0);
        check64({name, "_err_cnt"}, 64'(err_cnt), 64'd0);
        check64({name, "_last_rb"}, last_readback, 64'd0);
        check64({name, "_shadow"}, shadow, 64'd0);
    endtask

    localparam logic [63:0] W1 = 64'h0000_A5A5_1234_5678;
    localparam logic [63:0] W2 = 64'h0000_0F0F_CAFE_0001;
    localparam logic [63:0] W3 = 64'h0000_1111_2222_3333;
    localparam logic [63:0] W4 = 64'h0000_8000_0000_0001;
    localparam logic [63:0] W5 = 64'h0000_DEAD_BEEF_0042;
    localparam logic [63:0] W6 = 64'h0000_3C3C_5A5A_0F0F;
    localparam logic [63:0] W7 = 64'h0000_0123_4567_89AB;

    initial begin
        int w;
        int n;
        int s;
        host_req = 1'b0; host_data = 64'd0; refresh_en = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // clean pass: latency 1+48+5+48+1+4+1 = 108
        issue(W1, mk("clean", W1, 1'b0, 16'd0, W1, echo(W1, 1'b0), 1, 108), w);
        drain("clean");

        // bit 0 corrupted on the first two attempts: 2*110 + 108
        corrupt_until = eng_txn + 2;
        issue(W2, mk("retry", W2, 1'b0, 16'd2, W2, echo(W2, 1'b0), 3, 328), w);
        drain("retry");

        // always corrupted: 4 attempts, err set, shadow keeps W2
        always_corrupt = 1'b1;
        issue(W3, mk("fail", W3, 1'b1, 16'd6, W2, echo(W3, 1'b1), 4, 438), w);
        drain("fail");
        always_corrupt = 1'b0;

        // next host write clears err; upper host_data bits are dropped
        issue(64'hFFFF_8000_0000_0001, mk("clear", W4, 1'b0, 16'd6, W4, echo(W4, 1'b0), 1, 108), w);
        drain("clear");

        // swr stuck high: timeout after 1024 cycles in WAIT_LOW, then 4 gap cycles
        stuck_high = 1'b1;
        issue(W5, mk("timeout", W5, 1'b1, 16'd6, W4, echo(W4, 1'b0), 1, 1027), w);
        drain("timeout");
        stuck_high = 1'b0;
        repeat (5) @(negedge clk);

        // reset during WAIT_HIGH
        issue(W6, mk("aborted", W6, 1'b0, 16'd6, W6, echo(W6, 1'b0), 1, 108), w);
        n = 0;
        while (spi_swr !== 1'b0 && n < 500) begin @(negedge clk); n++; end
        check64("abort_swr_low", 64'(spi_swr), 64'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check64("midrst_idle_busy", 64'(busy), 64'd0);

        issue(W7, mk("after_rst", W7, 1'b0, 16'd0, W7, echo(W7, 1'b0), 1, 108), w);
        drain("after_rst");

`ifdef SPI_SEQ_REFRESH_EN
        // first refresh served 200 cycles after enable
        exp_q.push_back(mk("refresh1", W7, 1'b0, 16'd0, W7, echo(W7, 1'b0), 1, 108));
        refresh_en = 1'b1;
        repeat (400) @(negedge clk);
        check64("refresh1_drained", 64'(exp_q.size()), 64'd0);
        // host request on the same cycle as the second expiry: host first, refresh of the new word next
        issue(W1, mk("host_vs_refresh", W1, 1'b0, 16'd0, W1, echo(W1, 1'b0), 1, 108), w);
        check64("host_vs_refresh_ack_wait", 64'(w), 64'd1);
        exp_q.push_back(mk("refresh2", W1, 1'b0, 16'd0, W1, echo(W1, 1'b0), 1, 108));
        s = 0; n = 0;
        while (s < 2 && n < 1000) begin @(negedge clk); n++; if (done) s++; end
        refresh_en = 1'b0;
        check64("refresh_done_pulses", 64'(s), 64'd2);
        s = spi_en_total;
        repeat (300) @(negedge clk);
        check64("refresh_off_quiet", 64'(spi_en_total), 64'(s));
        check64("refresh_queue_empty", 64'(exp_q.size()), 64'd0);
`else
        // without the refresh feature, refresh_en starts nothing
        s = spi_en_total;
        refresh_en = 1'b1;
        repeat (300) @(negedge clk);
        check64("refresh_ignored", 64'(spi_en_total), 64'(s));
        refresh_en = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by 2 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_cfg_sequencer.md
Name: spi_cfg_sequencer

Overview:
- Controller in front of the 48-bit SPI configuration engine (write-shift, load pulse, read-shift).
- Accepts configuration words from the host, keeps a shadow copy of the last good word, and periodically rewrites the shadow word to the chip.
- Issues the engine start pulse, detects completion from the engine's `swr` profile, and verifies the readback against the written word.
- On mismatch, retries, and reports status and error counts to the host wire-outs.

Parameters:
- NDATA, 48, bits per SPI frame; must match the engine.
- MAX_RETRY, 3, extra attempts after a readback mismatch (0 disables retries).
- TIMEOUT_CYC, 1024, cycles allowed per phase before the transaction is aborted.
- REFRESH_CYC, 1000000, clk cycles between automatic shadow rewrites.
- GAP_CYC, 4, idle cycles enforced between engine transactions.

Ports:
- clk  in  1  system clock, same as the SPI engine.
- rst  in  1  asynchronous, active-high reset.
- host_req  in  1  level request to write host_data.
- host_data  in  64  configuration word; bits [NDATA-1:0] are used.
- host_ack  out  1  one-cycle pulse when host_data is captured.
- refresh_en  in  1  enables automatic shadow rewrite.
- spi_en  out  1  start pulse to the engine (one cycle).
- spi_masterdata  out  64  word presented to the engine; held stable for the whole transaction.
- spi_swr  in  1  engine swr output; low only during the readback shift.
- spi_readback  in  64  engine datareadback.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at the end of a transaction (pass or fail).
- err  out  1  sticky; set on final failure or timeout, cleared by an accepted host_req.
- err_cnt  out  16  saturating count of readback mismatches, including retried ones.
- last_readback  out  64  readback captured in CHECK.
- shadow  out  64  last word that passed verification.

Behaviour:
- Reset values:
  - All outputs 0, shadow included.
  - State IDLE, retry and timeout counters 0, refresh timer 0.
  - Reset mid-transaction aborts immediately. spi_en is deasserted; the engine is reset by the same rst.
- States:
  - IDLE:
    - If host_req: capture host_data into the working register, pulse host_ack, and go to START.
    - Else, if the refresh timer has expired and refresh_en is high: load shadow into the working register and go to START.
    - Host has priority when both are pending in the same cycle; the refresh stays pending and is served next.
  - START: assert spi_en for exactly 1 cycle, set busy=1, go to WAIT_LOW.
  - WAIT_LOW: wait for spi_swr==0 (readback phase begun), then go to WAIT_HIGH.
  - WAIT_HIGH: wait for spi_swr==1 (engine has returned to idle), then go to CHECK.
  - CHECK:
    - Capture last_readback.
    - Pass condition: spi_readback[NDATA-1-i] == working[i] for all i < NDATA. The chip echoes LSB-first and the engine shifts in MSB-first.
    - On pass: shadow <= working, then GAP.
    - On fail: err_cnt += 1 (saturating at 16'hFFFF). If the retry count is below MAX_RETRY, increment it and go to GAP, then START. Otherwise set err=1 and go to GAP, then IDLE.
  - GAP: wait GAP_CYC cycles, then START on retry, otherwise IDLE. On leaving towards IDLE, pulse done, set busy=0, and clear the retry counter.
- Timeout: in WAIT_LOW or WAIT_HIGH, a per-phase counter reaching TIMEOUT_CYC sets err=1 with no retry, and the block goes to GAP then IDLE.
- Refresh timer:
  - Counts clk cycles while refresh_en=1; cleared when refresh_en=0.
  - Wraps to 0 and latches a pending flag at REFRESH_CYC-1.
  - The pending flag clears when its transaction starts.
  - A refresh is suppressed, and the pending flag cleared, while shadow has never been loaded (valid bit = 0).
- Other rules:
  - host_req asserted while busy is not acked; the host holds the level until ack.
  - spi_masterdata bits [63:NDATA] are always 0.
  - Total latency for a clean pass is (start to done): 1 + 48 + 5 + 48 + 1 + GAP_CYC + engine idle cycle.

Optional Feature:
- Macro: SPI_SEQ_REFRESH_EN.
- Defined: the refresh timer, shadow valid bit and refresh path exist as described above.
- Undefined:
  - No timer.
  - refresh_en is ignored; only host requests start transactions.
  - shadow is still updated on every pass.

Decomposition:
- Shared package spi_seq_pkg:
  - state encoding localparams (IDLE, START, WAIT_LOW, WAIT_HIGH, CHECK, GAP);
  - SPI_NDATA = 48, shared with the engine;
  - bit-reverse compare function.
- One sub-module, spi_seq_refresh_timer:
  - counter plus pending flag, with refresh_en, clear and expire ports;
  - instantiated only under SPI_SEQ_REFRESH_EN.

Test Plan:
- Host write 64'h0000_A5A5_1234_5678, behavioural chip echoing LSB-first → one spi_en pulse, done after the expected latency, shadow = written word, err=0, err_cnt=0.
- Chip flips readback bit 0 on the first two attempts only, MAX_RETRY=3 → three spi_en pulses, pass on the 3rd, err_cnt=2, err=0.
- Chip always corrupts readback → 4 attempts, err=1, err_cnt=4, shadow unchanged; the next host_req clears err.
- Chip holds swr stuck high (engine disconnected) → timeout after TIMEOUT_CYC in WAIT_LOW, err=1, done pulse, busy=0.
- SPI_SEQ_REFRESH_EN, REFRESH_CYC=200, a host write followed by refresh_en=1 → shadow rewritten every 200 cycles. A host_req in the same cycle as expiry is served first, and the refresh runs directly after.
- Assert rst during WAIT_HIGH → all outputs 0 next cycle, no done pulse, and a fresh host_req afterwards completes normally.
